// File: rtl/tawas_pkg.sv
// -----------------------------------------------------------------------------
// tawas_pkg
//   Shared constants, types and helpers for the Tawas thread-slice sequencer.
//   Contents:
//     clog2()            constant-evaluable ceiling log2 (clog2(1) = 0)
//     TAWAS_NUM_THREADS  default hardware thread count
//     TAWAS_TW           thread-id width for the default thread count
//     slice_t            thread-id type for the default thread count
// -----------------------------------------------------------------------------
package tawas_pkg;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  localparam int TAWAS_NUM_THREADS = 4;
  localparam int TAWAS_TW          = clog2(TAWAS_NUM_THREADS);

  typedef logic [TAWAS_TW-1:0] slice_t;

endpackage

// File: rtl/tawas_slice_ctl_if.sv
// -----------------------------------------------------------------------------
// tawas_slice_ctl_if
//   Bundles the slice sequencer's control inputs and slot outputs.
//   Modports:
//     master : core side; drives enable/stall pulses, observes slot outputs
//     slave  : sequencer side; the reverse
//   Signals:
//     thread_en_set/clr  per-thread enable / disable pulses
//     stall_set/clr      remote load issued / returned, per thread
//     slice, slice_vld   current slot owner and its issue qualifier
//     slice_pipe         PIPE_DEPTH delayed slice taps, tap k at [k*TW +: TW]
//     vld_pipe           PIPE_DEPTH delayed slice_vld taps
//     thread_active      registered per-thread enable state
//     err_ovf            sticky per-thread counter over/underflow flag
// -----------------------------------------------------------------------------
interface tawas_slice_ctl_if
  import tawas_pkg::*;
#(
  parameter int NUM_THREADS = TAWAS_NUM_THREADS,
  parameter int PIPE_DEPTH  = 3
);
  localparam int TW = clog2(NUM_THREADS);

  logic [NUM_THREADS-1:0]   thread_en_set;
  logic [NUM_THREADS-1:0]   thread_en_clr;
  logic [NUM_THREADS-1:0]   stall_set;
  logic [NUM_THREADS-1:0]   stall_clr;
  logic [TW-1:0]            slice;
  logic                     slice_vld;
  logic [PIPE_DEPTH*TW-1:0] slice_pipe;
  logic [PIPE_DEPTH-1:0]    vld_pipe;
  logic [NUM_THREADS-1:0]   thread_active;
  logic [NUM_THREADS-1:0]   err_ovf;

  modport master (
    output thread_en_set, thread_en_clr, stall_set, stall_clr,
    input  slice, slice_vld, slice_pipe, vld_pipe, thread_active, err_ovf
  );

  modport slave (
    input  thread_en_set, thread_en_clr, stall_set, stall_clr,
    output slice, slice_vld, slice_pipe, vld_pipe, thread_active, err_ovf
  );

endinterface

// File: rtl/tawas_rr_next.sv
// -----------------------------------------------------------------------------
// tawas_rr_next
//   Combinational cyclic first-set search: starting at start_i and wrapping,
//   returns the first index whose mask bit is set.
//   Ports:
//     mask_i   in  N   candidate mask
//     start_i  in  TW  first index examined
//     idx_o    out TW  first set index (start_i when nothing is set)
//     found_o  out 1   some mask bit is set
// -----------------------------------------------------------------------------
module tawas_rr_next
  import tawas_pkg::*;
#(
  parameter int N  = TAWAS_NUM_THREADS,
  parameter int TW = clog2(N)
) (
  input  logic [N-1:0]  mask_i,
  input  logic [TW-1:0] start_i,
  output logic [TW-1:0] idx_o,
  output logic          found_o
);

  logic [TW-1:0] cand;

  // Walk the mask from start_i; N is a power of two so the add wraps for free.
  always_comb begin
    idx_o   = start_i;
    found_o = 1'b0;
    cand    = start_i;
    for (int i = 0; i < N; i++) begin
      cand = start_i + TW'(i);
      if (!found_o && mask_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end else begin
        idx_o   = idx_o;
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/tawas_slice_ctl.sv
// -----------------------------------------------------------------------------
// tawas_slice_ctl
//   Thread-slice sequencer for the Tawas barrel core. Chooses the thread that
//   owns each pipeline slot, qualifies it with a valid bit, tracks per-thread
//   enables and outstanding remote (raccoon) loads, and provides delayed taps
//   for the fetch, AU, LS and regfile stages.
//   Ports:
//     clk, rst  clock; asynchronous active-high reset
//     bus       tawas_slice_ctl_if.slave (enable/stall pulses in, slot info out)
//   Build option:
//     TAWAS_SLICE_SKIP_EN  when defined, disabled threads are skipped instead
//                          of leaving bubbles; default is strict round robin.
// -----------------------------------------------------------------------------
module tawas_slice_ctl
  import tawas_pkg::*;
#(
  parameter int                     NUM_THREADS  = TAWAS_NUM_THREADS,
  parameter int                     MAX_OUT      = 3,
  parameter int                     STALL_THRESH = 1,
  parameter int                     PIPE_DEPTH   = 3,
  parameter logic [NUM_THREADS-1:0] RESET_EN     = {{(NUM_THREADS-1){1'b0}}, 1'b1}
) (
  input logic              clk,
  input logic              rst,
  tawas_slice_ctl_if.slave bus
);

  localparam int TW = clog2(NUM_THREADS);
  localparam int CW = clog2(MAX_OUT + 1);

  logic [NUM_THREADS-1:0] en_vec;
  logic [NUM_THREADS-1:0] err_vec;
  logic [NUM_THREADS-1:0] issue_ok;
  logic [TW-1:0]          slice_q;
  logic [TW-1:0]          slice_inc;
  logic [TW-1:0]          nxt;
  logic                   vld_q;
  logic [TW-1:0]          slice_pipe_q [PIPE_DEPTH];
  logic [PIPE_DEPTH-1:0]  vld_pipe_q;

  for (genvar t = 0; t < NUM_THREADS; t++) begin : gen_thr
    logic          en_q;
    logic          en_d;
    logic          err_q;
    logic          err_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Enable (disable wins) and saturating outstanding-load counter.
    always_comb begin
      en_d  = en_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (bus.thread_en_clr[t]) begin
        en_d = 1'b0;
      end else if (bus.thread_en_set[t]) begin
        en_d = 1'b1;
      end else begin
        en_d = en_q;
      end
      case ({bus.stall_set[t], bus.stall_clr[t]})
        2'b10: begin
          if (cnt_q == CW'(MAX_OUT)) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        2'b01: begin
          if (cnt_q == '0) begin
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end

    // Per-thread state registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        en_q  <= RESET_EN[t];
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        en_q  <= en_d;
        cnt_q <= cnt_d;
        err_q <= err_d;
      end
    end

    assign en_vec[t]   = en_q;
    assign err_vec[t]  = err_q;
    assign issue_ok[t] = en_q & (cnt_q < CW'(STALL_THRESH));
  end

  assign slice_inc = slice_q + TW'(1);

`ifdef TAWAS_SLICE_SKIP_EN
  logic [TW-1:0] rr_idx;
  logic          rr_found;

  // Search starts one past the current owner, so a lone enabled owner
  // is found last and keeps the slot.
  tawas_rr_next #(
    .N  (NUM_THREADS),
    .TW (TW)
  ) u_rr_next (
    .mask_i  (en_vec),
    .start_i (slice_inc),
    .idx_o   (rr_idx),
    .found_o (rr_found)
  );

  assign nxt = rr_found ? rr_idx : slice_inc;
`else
  assign nxt = slice_inc;
`endif

  // Slot sequencer and delay taps; issue uses pre-edge thread state only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slice_q    <= '0;
      vld_q      <= 1'b0;
      vld_pipe_q <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        slice_pipe_q[k] <= '0;
      end
    end else begin
      slice_q         <= nxt;
      vld_q           <= issue_ok[nxt];
      slice_pipe_q[0] <= slice_q;
      vld_pipe_q[0]   <= vld_q;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        slice_pipe_q[k] <= slice_pipe_q[k-1];
        vld_pipe_q[k]   <= vld_pipe_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : gen_tap
    assign bus.slice_pipe[k*TW +: TW] = slice_pipe_q[k];
  end

  assign bus.slice         = slice_q;
  assign bus.slice_vld     = vld_q;
  assign bus.vld_pipe      = vld_pipe_q;
  assign bus.thread_active = en_vec;
  assign bus.err_ovf       = err_vec;

endmodule

// File: tb/tb_tawas_slice_ctl.sv
// -----------------------------------------------------------------------------
// tb_tawas_slice_ctl
//   Two sequencers sharing one stimulus stream: u0 with stall threshold 1 and
//   u1 with stall threshold 2. A slot-level model (thread rotation, counters,
//   tap history) predicts every output each cycle; directed literal checks pin
//   the model at the interesting points.
// -----------------------------------------------------------------------------
module tb_tawas_slice_ctl;
  import tawas_pkg::*;

  localparam int NT   = 4;
  localparam int PD   = 3;
  localparam int MAXO = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  tawas_slice_ctl_if #(.NUM_THREADS(NT), .PIPE_DEPTH(PD)) if0 ();
  tawas_slice_ctl_if #(.NUM_THREADS(NT), .PIPE_DEPTH(PD)) if1 ();

  assign if1.thread_en_set = if0.thread_en_set;
  assign if1.thread_en_clr = if0.thread_en_clr;
  assign if1.stall_set     = if0.stall_set;
  assign if1.stall_clr     = if0.stall_clr;

  tawas_slice_ctl #(
    .NUM_THREADS(NT), .MAX_OUT(MAXO), .STALL_THRESH(1), .PIPE_DEPTH(PD), .RESET_EN(4'hF)
  ) u0 (.clk(clk), .rst(rst), .bus(if0));

  tawas_slice_ctl #(
    .NUM_THREADS(NT), .MAX_OUT(MAXO), .STALL_THRESH(2), .PIPE_DEPTH(PD), .RESET_EN(4'hF)
  ) u1 (.clk(clk), .rst(rst), .bus(if1));

  // ---------------- model ----------------
  int m_slice;
  bit m_vld   [2];
  int m_tap_s [PD];
  bit m_tap_v [2][PD];
  bit m_en    [NT];
  int m_cnt   [NT];
  bit m_err   [NT];

  function automatic int model_nxt();
    int nx;
    nx = (m_slice + 1) % NT;
`ifdef TAWAS_SLICE_SKIP_EN
    // nearest enabled thread after the owner wins; owner itself is the last resort
    for (int k = NT; k >= 1; k--) begin
      if (m_en[(m_slice + k) % NT]) nx = (m_slice + k) % NT;
    end
`endif
    return nx;
  endfunction

  function automatic bit model_issue(input int t, input int thr);
    return m_en[t] && (m_cnt[t] < thr);
  endfunction

  function automatic logic [3:0] pack_en();
    logic [3:0] r;
    for (int t = 0; t < NT; t++) r[t] = m_en[t];
    return r;
  endfunction

  function automatic logic [3:0] pack_err();
    logic [3:0] r;
    for (int t = 0; t < NT; t++) r[t] = m_err[t];
    return r;
  endfunction

  // Model state advance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_slice  <= 0;
      m_vld[0] <= 1'b0;
      m_vld[1] <= 1'b0;
      for (int k = 0; k < PD; k++) begin
        m_tap_s[k]    <= 0;
        m_tap_v[0][k] <= 1'b0;
        m_tap_v[1][k] <= 1'b0;
      end
      for (int t = 0; t < NT; t++) begin
        m_en[t]  <= 1'b1;
        m_cnt[t] <= 0;
        m_err[t] <= 1'b0;
      end
    end else begin
      m_slice       <= model_nxt();
      m_vld[0]      <= model_issue(model_nxt(), 1);
      m_vld[1]      <= model_issue(model_nxt(), 2);
      m_tap_s[0]    <= m_slice;
      m_tap_v[0][0] <= m_vld[0];
      m_tap_v[1][0] <= m_vld[1];
      for (int k = 1; k < PD; k++) begin
        m_tap_s[k]    <= m_tap_s[k-1];
        m_tap_v[0][k] <= m_tap_v[0][k-1];
        m_tap_v[1][k] <= m_tap_v[1][k-1];
      end
      for (int t = 0; t < NT; t++) begin
        if (if0.thread_en_clr[t]) m_en[t] <= 1'b0;
        else if (if0.thread_en_set[t]) m_en[t] <= 1'b1;
        if (if0.stall_set[t] && !if0.stall_clr[t]) begin
          if (m_cnt[t] == MAXO) m_err[t] <= 1'b1;
          else m_cnt[t] <= m_cnt[t] + 1;
        end else if (if0.stall_clr[t] && !if0.stall_set[t]) begin
          if (m_cnt[t] == 0) m_err[t] <= 1'b1;
          else m_cnt[t] <= m_cnt[t] - 1;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input int d, input logic [1:0] s, input logic v,
                     input logic [5:0] sp, input logic [2:0] vp,
                     input logic [3:0] act, input logic [3:0] err);
    chk({tag, ".slice"}, {30'd0, s}, m_slice);
    chk({tag, ".vld"}, {31'd0, v}, {31'd0, m_vld[d]});
    for (int k = 0; k < PD; k++) begin
      chk({tag, ".slice_tap"}, {30'd0, sp[k*2 +: 2]}, m_tap_s[k]);
      chk({tag, ".vld_tap"}, {31'd0, vp[k]}, {31'd0, m_tap_v[d][k]});
    end
    chk({tag, ".active"}, {28'd0, act}, {28'd0, pack_en()});
    chk({tag, ".err_ovf"}, {28'd0, err}, {28'd0, pack_err()});
  endtask

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      cmp("u0", 0, if0.slice, if0.slice_vld, if0.slice_pipe, if0.vld_pipe,
          if0.thread_active, if0.err_ovf);
      cmp("u1", 1, if1.slice, if1.slice_vld, if1.slice_pipe, if1.vld_pipe,
          if1.thread_active, if1.err_ovf);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_slice(input int s);
    for (int i = 0; i < 8; i++) begin
      if (if0.slice == s[1:0]) break;
      step();
    end
    chk("wait_slice", {30'd0, if0.slice}, s);
  endtask

  int prev;

  initial begin
    rst = 1'b1;
    if0.thread_en_set = 4'b0000;
    if0.thread_en_clr = 4'b0000;
    if0.stall_set     = 4'b0000;
    if0.stall_clr     = 4'b0000;
    @(negedge clk);
    chk("rst_slice", {30'd0, if0.slice}, 32'd0);
    chk("rst_vld", {31'd0, if0.slice_vld}, 32'd0);
    chk("rst_taps", {26'd0, if0.slice_pipe}, 32'd0);
    chk("rst_active", {28'd0, if0.thread_active}, 32'hF);
    chk("rst_err", {28'd0, if0.err_ovf}, 32'd0);
    rst = 1'b0;

    // plain rotation: 1,2,3,0 all valid
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("rot_slice", {30'd0, if0.slice}, i % 4);
      chk("rot_vld", {31'd0, if0.slice_vld}, 32'd1);
    end
    chk("rot_tap2", {30'd0, if0.slice_pipe[5:4]}, 32'd1);
    chk("rot_vtap2", {31'd0, if0.vld_pipe[2]}, 32'd1);

    // remote load on thread 2 issued while slot 1 is current
    step();
    chk("stl_pre", {30'd0, if0.slice}, 32'd1);
    if0.stall_set = 4'b0100;
    step();
    if0.stall_set = 4'b0000;
    chk("stl_slot2_still", {31'd0, if0.slice_vld}, 32'd1);
    repeat (4) step();
    chk("stl_slice", {30'd0, if0.slice}, 32'd2);
    chk("stl_u0_blocked", {31'd0, if0.slice_vld}, 32'd0);
    chk("stl_u1_open", {31'd0, if1.slice_vld}, 32'd1);
    if0.stall_clr = 4'b0100;
    step();
    if0.stall_clr = 4'b0000;
    repeat (3) step();
    chk("stl_resume", {31'd0, if0.slice_vld}, 32'd1);

    // two loads on thread 1: threshold-2 instance blocks until one returns
    if0.stall_set = 4'b0010;
    step();
    step();
    if0.stall_set = 4'b0000;
    step();
    chk("thr_slice", {30'd0, if0.slice}, 32'd1);
    chk("thr_u1_blocked", {31'd0, if1.slice_vld}, 32'd0);
    if0.stall_clr = 4'b0010;
    step();
    if0.stall_clr = 4'b0000;
    repeat (3) step();
    chk("thr_u1_resume", {31'd0, if1.slice_vld}, 32'd1);
    chk("thr_u0_blocked", {31'd0, if0.slice_vld}, 32'd0);
    if0.stall_clr = 4'b0010;
    step();
    if0.stall_clr = 4'b0000;

    // four loads on thread 0 saturate at 3 and flag overflow
    if0.stall_set = 4'b0001;
    repeat (4) step();
    if0.stall_set = 4'b0000;
    chk("ovf_u0", {28'd0, if0.err_ovf}, 32'h1);
    chk("ovf_u1", {28'd0, if1.err_ovf}, 32'h1);
    if0.stall_clr = 4'b0001;
    repeat (3) step();
    if0.stall_clr = 4'b0000;
    step();
    chk("ovf_sticky", {28'd0, if0.err_ovf}, 32'h1);
    if0.stall_clr = 4'b1000;
    step();
    if0.stall_clr = 4'b0000;
    chk("unf_t3", {28'd0, if0.err_ovf}, 32'h9);

    // simultaneous enable set/clear, simultaneous stall set/clear
    if0.thread_en_set = 4'b0010;
    if0.thread_en_clr = 4'b0010;
    step();
    if0.thread_en_set = 4'b0000;
    if0.thread_en_clr = 4'b0000;
    chk("en_clr_wins", {28'd0, if0.thread_active}, 32'hD);
    if0.stall_set = 4'b0100;
    if0.stall_clr = 4'b0100;
    step();
    if0.stall_set = 4'b0000;
    if0.stall_clr = 4'b0000;
    wait_slice(2);
    chk("stl_both_nochg", {31'd0, if0.slice_vld}, 32'd1);
`ifndef TAWAS_SLICE_SKIP_EN
    wait_slice(1);
    chk("rr_bubble", {31'd0, if0.slice_vld}, 32'd0);
`endif

    // only threads 0 and 2 enabled
    if0.thread_en_clr = 4'b1010;
    step();
    if0.thread_en_clr = 4'b0000;
    chk("en_02", {28'd0, if0.thread_active}, 32'h5);
    step();
    step();
`ifdef TAWAS_SLICE_SKIP_EN
    prev = int'(if0.slice);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("skip_alt", {30'd0, if0.slice}, (prev == 0) ? 32'd2 : 32'd0);
      chk("skip_alt_vld", {31'd0, if0.slice_vld}, 32'd1);
      prev = int'(if0.slice);
    end
`else
    wait_slice(3);
    chk("rr_t3_bubble", {31'd0, if0.slice_vld}, 32'd0);
`endif

    // only thread 3 enabled
    if0.thread_en_set = 4'b1000;
    if0.thread_en_clr = 4'b0101;
    step();
    if0.thread_en_set = 4'b0000;
    if0.thread_en_clr = 4'b0000;
    step();
    step();
`ifdef TAWAS_SLICE_SKIP_EN
    for (int i = 0; i < 3; i++) begin
      step();
      chk("skip_solo", {30'd0, if0.slice}, 32'd3);
      chk("skip_solo_vld", {31'd0, if0.slice_vld}, 32'd1);
    end
`else
    wait_slice(3);
    chk("rr_solo_vld", {31'd0, if0.slice_vld}, 32'd1);
    step();
    chk("rr_solo_next", {30'd0, if0.slice}, 32'd0);
    chk("rr_solo_bubble", {31'd0, if0.slice_vld}, 32'd0);
`endif

    // reset in the middle of operation
    if0.stall_set = 4'b1000;
    step();
    if0.stall_set = 4'b0000;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_slice", {30'd0, if0.slice}, 32'd0);
    chk("mid_rst_vld", {31'd0, if0.slice_vld}, 32'd0);
    chk("mid_rst_active", {28'd0, if0.thread_active}, 32'hF);
    chk("mid_rst_err", {28'd0, if1.err_ovf}, 32'd0);
    chk("mid_rst_taps", {29'd0, if1.vld_pipe}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
